// File: rtl/reg_bank_scoreboard.sv
// Decode-stage register bank with two bypassed combinational read ports, one WB write port,
// and a per-register pending-write scoreboard that stalls decode on read-after-write hazards.
module reg_bank_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              rd_use1,
  input  logic              rd_use2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic [5:0]        pending_cnt
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_next;
  logic [5:0]          cnt_next;
  logic                wb_write;
  logic                bypass1;
  logic                bypass2;
  logic                hazard1;
  logic                hazard2;
  logic                issue_accept;

  assign wb_write = wb_en && (wb_addr != '0);
  assign bypass1  = wb_write && (wb_addr == rd_addr1);
  assign bypass2  = wb_write && (wb_addr == rd_addr2);

  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (rd_addr1 != '0) rd_data1 = bypass1 ? wb_data : regs[rd_addr1];
    if (rd_addr2 != '0) rd_data2 = bypass2 ? wb_data : regs[rd_addr2];
  end

  // A writeback landing this cycle resolves the hazard through the bypass.
  assign hazard1      = rd_use1 && (rd_addr1 != '0) && pending[rd_addr1] && !bypass1;
  assign hazard2      = rd_use2 && (rd_addr2 != '0) && pending[rd_addr2] && !bypass2;
  assign stall        = hazard1 || hazard2;
  assign issue_accept = issue_en && !stall && (issue_rd != '0);

  // Clear first, then set, so a same-cycle issue to the written register keeps it pending.
  always_comb begin
    pending_next = pending;
    if (wb_write)     pending_next[wb_addr]  = 1'b0;
    if (issue_accept) pending_next[issue_rd] = 1'b1;
    cnt_next = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) cnt_next = cnt_next + 6'(pending_next[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      pending     <= '0;
      pending_cnt <= '0;
    end else begin
      if (wb_write) regs[wb_addr] <= wb_data;
      pending     <= pending_next;
      pending_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_reg_bank_scoreboard.sv
// Self-checking bench for reg_bank_scoreboard: directed scenarios plus randomized traffic
// compared against an array/bitmask reference model.
module tb_reg_bank_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        rd_use1;
  logic        rd_use2;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall;
  logic [5:0]  pending_cnt;

  int checks;
  int errors;

  logic [31:0] m_regs [32];
  logic [31:0] m_pend;

  reg_bank_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_use1(rd_use1), .rd_use2(rd_use2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(stall), .pending_cnt(pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic model_stall();
    logic h1, h2;
    h1 = rd_use1 && rd_addr1 != 0 && m_pend[rd_addr1] && !(wb_en && wb_addr == rd_addr1);
    h2 = rd_use2 && rd_addr2 != 0 && m_pend[rd_addr2] && !(wb_en && wb_addr == rd_addr2);
    return h1 || h2;
  endfunction

  function automatic int model_cnt();
    return $countones(m_pend);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_pend = 32'h0;
  endtask

  task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic u1, input logic u2,
                       input logic ie, input logic [4:0] ird,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    rd_addr1 = a1; rd_addr2 = a2; rd_use1 = u1; rd_use2 = u2;
    issue_en = ie; issue_rd = ird; wb_en = we; wb_addr = wa; wb_data = wd;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
  endtask

  // Advance the model with the current inputs, then let the DUT take the same edge.
  task automatic tick();
    logic st;
    st = model_stall();
    if (wb_en && wb_addr != 0) begin
      m_regs[wb_addr] = wb_data;
      m_pend[wb_addr] = 1'b0;
    end
    if (issue_en && !st && issue_rd != 0) m_pend[issue_rd] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_clear();
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (pending_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", pending_cnt); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(5'd5, 5'd0, 0, 0, 0, 5'd0, 1, 5'd5, 32'h1111_0005); tick();
    drive(5'd0, 5'd0, 0, 0, 1, 5'd3, 1, 5'd6, 32'h2222_0006); tick();
    drive(5'd5, 5'd3, 0, 1, 0, 5'd0, 0, 5'd0, 32'h0);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_prestall: got %b want 1", stall); end
    checks++; if (rd_data1 !== 32'h1111_0005) begin errors++; $display("FAIL reset_preload: got %h want 11110005", rd_data1); end
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++; if (rd_data1 !== 32'h0) begin errors++; $display("FAIL reset_rd1: got %h want 0", rd_data1); end
    rd_addr2 = 5'd6;
    #1;
    checks++; if (rd_data2 !== 32'h0) begin errors++; $display("FAIL reset_rd2: got %h want 0", rd_data2); end
    checks++; if (pending_cnt !== 6'd0) begin errors++; $display("FAIL reset_midcnt: got %0d want 0", pending_cnt); end
    rd_addr2 = 5'd3;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_midstall: got %b want 0", stall); end
    #2 rst_n = 1'b1;
    idle();
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    do_reset();
    drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 5'd5, 32'hDEAD_BEEF); tick();
    drive(5'd5, 5'd0, 1, 0, 0, 5'd0, 0, 5'd0, 32'h0);
    #1;
    checks++; if (rd_data1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_r5: got %h want deadbeef", rd_data1); end
    drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 5'd0, 32'h0000_1234);
    #1;
    checks++; if (rd_data1 !== 32'h0) begin errors++; $display("FAIL wr_r0_same: got %h want 0", rd_data1); end
    tick();
    wb_en = 1'b0;
    #1;
    checks++; if (rd_data1 !== 32'h0) begin errors++; $display("FAIL wr_r0_next: got %h want 0", rd_data1); end
  endtask

  task automatic test_bypass();
    do_reset();
    drive(5'd0, 5'd7, 0, 0, 0, 5'd0, 1, 5'd7, 32'hA5A5_A5A5);
    #1;
    checks++; if (rd_data2 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL bypass_rd2: got %h want a5a5a5a5", rd_data2); end
    tick();
    idle();
  endtask

  task automatic test_raw_stall();
    do_reset();
    drive(5'd0, 5'd0, 0, 0, 1, 5'd3, 0, 5'd0, 32'h0); tick();
    drive(5'd3, 5'd0, 1, 0, 1, 5'd9, 0, 5'd0, 32'h0);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b want 1", stall); end
    tick();
    checks++; if (pending_cnt !== 6'd1) begin errors++; $display("FAIL raw_ignored_issue: got %0d want 1", pending_cnt); end
    drive(5'd3, 5'd0, 1, 0, 1, 5'd9, 1, 5'd3, 32'h1111_2222);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_release: got %b want 0", stall); end
    checks++; if (rd_data1 !== 32'h1111_2222) begin errors++; $display("FAIL raw_bypass: got %h want 11112222", rd_data1); end
    tick();
    idle();
    #1;
    checks++; if (pending_cnt !== 6'd1) begin errors++; $display("FAIL raw_swap_cnt: got %0d want 1", pending_cnt); end
  endtask

  task automatic test_collision();
    do_reset();
    drive(5'd0, 5'd0, 0, 0, 1, 5'd4, 0, 5'd0, 32'h0); tick();
    drive(5'd0, 5'd0, 0, 0, 1, 5'd4, 1, 5'd4, 32'h0000_0444); tick();
    idle();
    #1;
    checks++; if (pending_cnt !== 6'd1) begin errors++; $display("FAIL coll_cnt: got %0d want 1", pending_cnt); end
    rd_addr1 = 5'd4; rd_use1 = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL coll_pending: got %b want 1", stall); end
    checks++; if (rd_data1 !== 32'h0000_0444) begin errors++; $display("FAIL coll_data: got %h want 00000444", rd_data1); end
    idle();
    drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 5'd12, 32'h0000_0CCC); tick();
    idle();
    #1;
    checks++; if (pending_cnt !== 6'd1) begin errors++; $display("FAIL wb_nonpending_cnt: got %0d want 1", pending_cnt); end
  endtask

  task automatic test_unused_operand();
    do_reset();
    drive(5'd0, 5'd0, 0, 0, 1, 5'd6, 0, 5'd0, 32'h0); tick();
    drive(5'd0, 5'd6, 0, 0, 0, 5'd0, 0, 5'd0, 32'h0);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL unused_stall: got %b want 0", stall); end
    rd_use2 = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL used_stall: got %b want 1", stall); end
    idle();
    for (int r = 0; r < 32; r++) begin
      drive(5'd0, 5'd0, 0, 0, 1, 5'(r), 0, 5'd0, 32'h0);
      tick();
    end
    idle();
    #1;
    checks++; if (pending_cnt !== 6'd31) begin errors++; $display("FAIL fill_cnt: got %0d want 31", pending_cnt); end
  endtask

  task automatic test_random();
    logic [4:0] a1, a2, ird, wa;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      a1  = 5'($urandom_range(0, 7));
      a2  = 5'($urandom_range(0, 7));
      ird = 5'($urandom_range(0, 7));
      wa  = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) begin
        a1 = 5'($urandom_range(0, 31)); ird = 5'($urandom_range(0, 31));
      end
      drive(a1, a2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), ird,
            1'($urandom_range(0, 2) == 0), wa, $urandom);
      #1;
      checks++; if (rd_data1 !== model_rd(rd_addr1)) begin errors++; $display("FAIL rand_rd1 #%0d: got %h want %h", n, rd_data1, model_rd(rd_addr1)); end
      checks++; if (rd_data2 !== model_rd(rd_addr2)) begin errors++; $display("FAIL rand_rd2 #%0d: got %h want %h", n, rd_data2, model_rd(rd_addr2)); end
      checks++; if (stall !== model_stall()) begin errors++; $display("FAIL rand_stall #%0d: got %b want %b", n, stall, model_stall()); end
      checks++; if (pending_cnt !== 6'(model_cnt())) begin errors++; $display("FAIL rand_cnt #%0d: got %0d want %0d", n, pending_cnt, model_cnt()); end
      tick();
    end
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    model_clear();
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_raw_stall();
    test_collision();
    test_unused_operand();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
